instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the CalcuTEC single-cycle core. It sits directly upstream of the control decoder. It owns the program counter and issues requests to instruction memory over a req/ack handshake. It holds the fetched word stable and splits it into the `cond`/`op`/`funct`/`sh` fields the control decoder consumes. It redirects the PC when the decoder reports a taken branch.

## Interface
Parameters:
- `ADDR_W`, default 32: PC / instruction address width.
- `RESET_PC`, default 0: PC loaded on reset; must be word aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDR_W  fetch address; always word aligned.
- `imem_ack`  in  1  memory accepted request; `imem_rdata` valid this cycle. Only meaningful while `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `instr_valid`  out  1  `instr` holds a fetched instruction.
- `instr_ready`  in  1  downstream consumes `instr` this cycle.
- `instr`  out  32  held instruction word.
- `cond`  out  4  `instr[31:28]`.
- `op`  out  2  `instr[27:26]`.
- `funct`  out  6  `instr[25:20]`.
- `sh`  out  2  `instr[6:5]`.
- `instr_pc`  out  ADDR_W  address `instr` was fetched from.
- `br_taken`  in  1  control's `sel_PC` for the held instruction, already condition-gated.
- `br_imm24`  in  24  `instr[23:0]` branch offset from the immediate path.
- `retired_cnt`  out  32  count of consumed instructions.

## Operation
- State `pc` holds the next fetch address. There are two FSM states: FETCH and VALID.
- Reset values: `pc`=RESET_PC, state=FETCH, `instr`=0, `instr_pc`=RESET_PC, `retired_cnt`=0. Outputs during the reset cycle: `instr_valid`=0, `imem_req`=0.
- `imem_addr`=`pc` at all times.
- FETCH:
  - `imem_req`=1 and `instr_valid`=0.
  - On `imem_ack`: `instr`<=`imem_rdata`, `instr_pc`<=`pc`, `pc`<=`pc`+4, go to VALID.
  - Otherwise remain in FETCH; the request persists.
- VALID:
  - `instr_valid`=1. `instr` and `instr_pc` are held stable until consumed.
  - Not `instr_ready`: hold everything, `imem_req`=0.
  - `instr_ready` and `br_taken`: `pc`<=`instr_pc`+8+(sext(`br_imm24`)<<2), `imem_req`=0, go to FETCH. The branch target appears on `imem_addr` the next cycle.
  - `instr_ready` and not `br_taken`: `imem_req`=1 speculatively at `pc`, which is already `instr_pc`+4.
    - With `imem_ack`: load the new word as in FETCH and stay in VALID. This gives one instruction per cycle.
    - Without `imem_ack`: the request is withdrawn; go to FETCH and reissue the same address.
- `br_taken` and `br_imm24` are ignored unless `instr_valid` and `instr_ready` are both 1.
- `imem_req` depends combinationally on `instr_ready` and `br_taken` in VALID only. Memory must tolerate a request that is withdrawn without an ack.
- `retired_cnt` increments by 1 on every cycle with `instr_valid`&`instr_ready`. It wraps from 0xFFFFFFFF to 0.
- Arithmetic is modulo 2^ADDR_W. PC+4 and the branch target wrap silently. Bits [1:0] of `pc` are always 0.
- `imem_ack` while `imem_req`=0 is ignored.

## Timing
- Fetch latency: an instruction is visible on `instr`/`instr_valid` the cycle after the ack cycle.
- First request: the cycle after `rst` deasserts, at RESET_PC.
- With a zero-wait memory (ack in the request cycle) and `instr_ready` tied high, throughput is 1 instruction/cycle.
- Each memory wait cycle adds 1 cycle.
- A taken branch costs 1 bubble cycle (FETCH at the target) plus the memory latency.
- Reset asserted mid-operation, in any state: the in-flight fetch is abandoned and all state returns to reset values on that edge. An `imem_ack` in the reset cycle is ignored.
- The field outputs are pure slices of the `instr` register. They change only on a load edge.

## Test plan
- Reset / first fetch:
  - Stimulus: `rst` 2 cycles, RESET_PC=0x100.
  - Required: `imem_req`=0 and `instr_valid`=0 during reset; the next cycle shows `imem_req`=1, `imem_addr`=0x100.
- Back-to-back zero-wait fetch:
  - Stimulus: ack every request, memory returns the address as data, `instr_ready`=1.
  - Required: `instr` = 0x0, 0x4, 0x8 on consecutive cycles; `retired_cnt` increments each cycle.
- Wait states and backpressure:
  - Stimulus: ack delayed 2 cycles; `instr_ready` low 3 cycles.
  - Required: `imem_addr` is stable during the wait; `instr`, `cond`, `op`, `funct`, `sh` are held; no request while VALID and not ready.
- Taken branch, negative offset:
  - Stimulus: `instr_pc`=0x40, `br_imm24`=0xFFFFFC, `br_taken`=1, `instr_ready`=1.
  - Required: next cycle `imem_addr`=0x38, `instr_valid`=0; the fall-through 0x44 is never requested.
- Branch ignored without consume:
  - Stimulus: `br_taken`=1 with `instr_ready`=0.
  - Required: `pc` is unchanged and `instr` is held.
- Wrap and mid-fetch reset:
  - Stimulus: PC at 0xFFFFFFFC, sequential fetch.
  - Required: the next `imem_addr` is 0x0.
  - Stimulus: assert `rst` while FETCH awaits ack.
  - Required: the next cycle has all reset values and `imem_addr`=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the CalcuTEC single-cycle core.
// Owns the PC, fetches words over a req/ack memory handshake, holds the
// fetched word for the control decoder, and redirects on taken branches.
//
// Handshakes:
//   imem_req/imem_ack : a fetch transfers on any cycle with imem_req=1 and
//                       imem_ack=1; imem_rdata is sampled on that edge. An ack
//                       without a request is ignored. A request may be
//                       withdrawn without an ack.
//   instr_valid/instr_ready : the held instruction is consumed on any cycle
//                       with both high; instr/instr_pc are stable while
//                       instr_valid=1 and instr_ready=0.
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [1:0]        sh,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              br_taken,
    input  logic [23:0]       br_imm24,
    output logic [31:0]       retired_cnt,
    output logic              dbg_state_o
);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]       retired_q, retired_d;

    logic              req_raw;
    logic              valid_raw;
    logic              load;
    logic signed [25:0] br_off26;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;

    // Branch target: word offset sign-extended, relative to instr_pc + 8.
    always_comb begin
        br_off26  = signed'({br_imm24, 2'b00});
        br_off    = ADDR_W'(br_off26);
        br_target = instr_pc_q + ADDR_W'(8) + br_off;
    end

    // Next-state and handshake logic; a load captures the word at pc.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        retired_d  = retired_q;
        req_raw    = 1'b0;
        valid_raw  = 1'b0;
        load       = 1'b0;
        case (state_q)
            FETCH: begin
                req_raw = 1'b1;
                if (imem_ack) begin
                    load    = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                valid_raw = 1'b1;
                if (instr_ready) begin
                    retired_d = retired_q + 32'd1;
                    if (br_taken) begin
                        // Redirect; the target is fetched from FETCH next cycle.
                        pc_d    = br_target;
                        state_d = FETCH;
                    end else begin
                        // Speculative fetch of pc (already instr_pc + 4).
                        req_raw = 1'b1;
                        if (imem_ack) begin
                            load = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: state_d = FETCH;
        endcase
        if (load) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(4);
        end
    end

    // State registers with synchronous reset; reset wins over any ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= RESET_PC;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= {pc_d[ADDR_W-1:2], 2'b00};
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            retired_q  <= retired_d;
        end
    end

    // Outputs: handshake outputs are suppressed during the reset cycle.
    always_comb begin
        imem_req    = req_raw & ~rst;
        instr_valid = valid_raw & ~rst;
        imem_addr   = pc_q;
        instr       = instr_q;
        cond        = instr_q[31:28];
        op          = instr_q[27:26];
        funct       = instr_q[25:20];
        sh          = instr_q[6:5];
        instr_pc    = instr_pc_q;
        retired_cnt = retired_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch (RESET_PC = 0x100).
module tb_instr_fetch;

  localparam int ADDR_W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [3:0]        cond;
  logic [1:0]        op;
  logic [5:0]        funct;
  logic [1:0]        sh;
  logic [ADDR_W-1:0] instr_pc;
  logic              br_taken;
  logic [23:0]       br_imm24;
  logic [31:0]       retired_cnt;
  logic              dbg_state;

  // memory model: returns its address as data, or a fixed word
  logic        use_addr_data;
  logic [31:0] fixed_word;
  always_comb imem_rdata = use_addr_data ? imem_addr : fixed_word;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .cond(cond), .op(op),
    .funct(funct), .sh(sh), .instr_pc(instr_pc), .br_taken(br_taken),
    .br_imm24(br_imm24), .retired_cnt(retired_cnt), .dbg_state_o(dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic r, input logic b, input logic [23:0] imm);
    imem_ack    = a;
    instr_ready = r;
    br_taken    = b;
    br_imm24    = imm;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    use_addr_data = 1'b1;
    fixed_word = 32'h0;
    drive(1'b1, 1'b0, 1'b0, 24'h0);

    // reset: two cycles, ack ignored
    chk("rst_req_pre", {31'd0, imem_req}, 32'd0);
    chk("rst_valid_pre", {31'd0, instr_valid}, 32'd0);
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'h100);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);

    // first request at RESET_PC
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h100);

    // back-to-back zero-wait
    tick();
    chk("b2b_instr0", instr, 32'h100);
    chk("b2b_valid0", {31'd0, instr_valid}, 32'd1);
    chk("b2b_pc0", instr_pc, 32'h100);
    chk("b2b_ret0", retired_cnt, 32'd0);
    chk("b2b_addr0", imem_addr, 32'h104);
    chk("b2b_req0", {31'd0, imem_req}, 32'd1);
    tick();
    chk("b2b_instr1", instr, 32'h104);
    chk("b2b_ret1", retired_cnt, 32'd1);
    tick();
    chk("b2b_instr2", instr, 32'h108);
    chk("b2b_ret2", retired_cnt, 32'd2);
    chk("b2b_addr2", imem_addr, 32'h10C);

    // speculative request without ack -> back to FETCH, same address
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    tick();
    chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    chk("wait_ret", retired_cnt, 32'd3);
    chk("wait_addr0", imem_addr, 32'h10C);
    chk("wait_req0", {31'd0, imem_req}, 32'd1);
    tick();
    chk("wait_addr1", imem_addr, 32'h10C);
    chk("wait_instr_hold", instr, 32'h108);
    tick();
    chk("wait_addr2", imem_addr, 32'h10C);
    chk("wait_req2", {31'd0, imem_req}, 32'd1);

    // ack with a field-rich word
    use_addr_data = 1'b0;
    fixed_word = 32'hA5F30C47;
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    tick();
    chk("fld_instr", instr, 32'hA5F30C47);
    chk("fld_pc", instr_pc, 32'h10C);

    // backpressure 3 cycles; ack and branch must be ignored
    fixed_word = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, (i == 1), 24'h000010);
      chk("bp_req", {31'd0, imem_req}, 32'd0);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      tick();
      chk("bp_instr", instr, 32'hA5F30C47);
      chk("bp_cond", {28'd0, cond}, 32'hA);
      chk("bp_op", {30'd0, op}, 32'h1);
      chk("bp_funct", {26'd0, funct}, 32'h1F);
      chk("bp_sh", {30'd0, sh}, 32'h2);
      chk("bp_addr", imem_addr, 32'h110);
      chk("bp_ret", retired_cnt, 32'd3);
    end

    // consume and fetch 0x110
    use_addr_data = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    tick();
    chk("c_instr", instr, 32'h110);
    chk("c_ret", retired_cnt, 32'd4);

    // branch 0x110 -> 0x40 (offset -0x36 words)
    drive(1'b1, 1'b1, 1'b1, 24'hFFFFCA);
    chk("br1_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("br1_addr", imem_addr, 32'h40);
    chk("br1_valid", {31'd0, instr_valid}, 32'd0);
    chk("br1_ret", retired_cnt, 32'd5);
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    tick();
    chk("br1_instr", instr, 32'h40);
    chk("br1_ipc", instr_pc, 32'h40);

    // negative branch from 0x40, imm 0xFFFFFC -> 0x38; 0x44 never requested
    drive(1'b1, 1'b1, 1'b1, 24'hFFFFFC);
    chk("br2_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("br2_addr", imem_addr, 32'h38);
    chk("br2_valid", {31'd0, instr_valid}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    tick();
    chk("br2_instr", instr, 32'h38);

    // branch 0x38 -> 0xFFFFFFFC, then sequential wrap to 0
    drive(1'b1, 1'b1, 1'b1, 24'hFFFFEF);
    tick();
    chk("br3_addr", imem_addr, 32'hFFFFFFFC);
    chk("br3_ret", retired_cnt, 32'd7);
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    tick();
    chk("wrap_instr", instr, 32'hFFFFFFFC);
    chk("wrap_ipc", instr_pc, 32'hFFFFFFFC);
    chk("wrap_addr", imem_addr, 32'h0);

    // withdraw request: FETCH awaits ack at 0x0
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    tick();
    chk("pre_rst_state", {31'd0, dbg_state}, 32'd0);
    chk("pre_rst_addr", imem_addr, 32'h0);
    chk("pre_rst_ret", retired_cnt, 32'd8);

    // mid-fetch reset with an ack that must be ignored
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 24'h0);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_ipc", instr_pc, 32'h100);
    chk("mid_rst_ret", retired_cnt, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h100);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 24'h0);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
